// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
// ----------------------------------------------------------------------------
// Main control unit of a multi-cycle RV32I core. A Moore FSM walks each
// instruction through fetch, decode, execute, memory and write-back. Every
// datapath select and write strobe is driven from the current state, plus the
// latched instruction fields and the ALU flags.
// Unsupported instructions park the FSM in TRAP until the next reset.
//
// Handshake: there is no valid/ready interface. Strobes are single-cycle
// Moore outputs. The datapath acts on them at the next rising edge of clk.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   opcode, funct3,     fields of the instruction register
//   funct7_5
//   zero, sign          ALU flags (result == 0, result[31])
//   pc_write, adr_src, memory_write, ir_write, register_write   strobes/selects
//   result_src, alu_src_a, alu_src_b, alu_control, immediate_source  datapath codes
//   illegal             high while in TRAP
//   dbg_state_o         current FSM state, for checkers and debug
// ----------------------------------------------------------------------------
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       sign,
  output logic       pc_write,
  output logic       adr_src,
  output logic       memory_write,
  output logic       ir_write,
  output logic       register_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] immediate_source,
  output logic       illegal,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_JAL, S_JALR_LINK, S_JALR_JUMP,
    S_BRANCH, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  state_t     state_q, state_d;
  logic [2:0] alu_fn;
  logic       alu_ok;
  logic       br_taken;
  logic       br_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign dbg_state_o = state_q;

  // ALU operation for EXEC_R / EXEC_I. Subtract only exists for R-type.
  always_comb begin
    alu_fn = ALU_ADD;
    alu_ok = 1'b1;
    case (funct3)
      3'b000:  alu_fn = (state_q == S_EXEC_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b100:  alu_fn = ALU_XOR;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_ok = 1'b0;
    endcase
  end

  // Branch condition from the flags of rs1 - rs2.
  always_comb begin
    br_taken = 1'b0;
    br_ok    = 1'b1;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = sign;
      3'b101:  br_taken = !sign;
      default: br_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    pc_write         = 1'b0;
    adr_src          = 1'b0;
    memory_write     = 1'b0;
    ir_write         = 1'b0;
    register_write   = 1'b0;
    result_src       = 2'b00;
    alu_src_a        = 2'b00;
    alu_src_b        = 2'b00;
    alu_control      = ALU_ADD;
    immediate_source = 3'b000;
    illegal          = 1'b0;
    // While reset is asserted every output stays at its quiet default.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ir_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_d    = S_DECODE;
        end
        S_DECODE: begin
          // ALU-out captures old PC + imm, the branch/jal target.
          alu_src_a        = 2'b01;
          alu_src_b        = 2'b01;
          immediate_source = (opcode == OP_JAL) ? 3'b011 : 3'b010;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
            OP_R:              state_d = S_EXEC_R;
            OP_I:              state_d = S_EXEC_I;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR_LINK;
            OP_BR:             state_d = S_BRANCH;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_TRAP;
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a        = 2'b10;
          alu_src_b        = 2'b01;
          // opcode[5] separates store (S-immediate) from load (I-immediate).
          immediate_source = opcode[5] ? 3'b001 : 3'b000;
          state_d          = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          adr_src = 1'b1;
          state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          result_src     = 2'b01;
          register_write = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEM_WRITE: begin
          adr_src      = 1'b1;
          memory_write = 1'b1;
          state_d      = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a   = 2'b10;
          alu_control = alu_fn;
          state_d     = alu_ok ? S_ALU_WB : S_TRAP;
        end
        S_EXEC_I: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = alu_fn;
          state_d     = alu_ok ? S_ALU_WB : S_TRAP;
        end
        S_ALU_WB: begin
          register_write = 1'b1;
          state_d        = S_FETCH;
        end
        S_JAL: begin
          // PC takes the target held in ALU-out while the ALU forms old PC + 4.
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          state_d   = S_ALU_WB;
        end
        S_JALR_LINK: begin
          alu_src_a      = 2'b01;
          alu_src_b      = 2'b10;
          result_src     = 2'b10;
          register_write = 1'b1;
          state_d        = S_JALR_JUMP;
        end
        S_JALR_JUMP: begin
          // rs1 was latched in DECODE, so a link into rd == rs1 is harmless.
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          pc_write    = br_ok & br_taken;
          state_d     = br_ok ? S_FETCH : S_TRAP;
        end
        S_LUI: begin
          immediate_source = 3'b100;
          result_src       = 2'b11;
          register_write   = 1'b1;
          state_d          = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: state_d = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: a vector table with hand-derived cycle
// counts, a few hand-written reset and trap sequences, and random instructions.
// All of it is checked cycle by cycle against a per-instruction step-list model.
module tb_multi_cycle_controller;
  localparam int W        = 18;
  localparam int TRAP_CYC = 12;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, sign;
  logic       pc_write, adr_src, memory_write, ir_write, register_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, immediate_source;
  logic [3:0] dbg_state;
  logic [W-1:0] got;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .sign(sign),
    .pc_write(pc_write), .adr_src(adr_src), .memory_write(memory_write),
    .ir_write(ir_write), .register_write(register_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .immediate_source(immediate_source),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  assign got = {pc_write, adr_src, memory_write, ir_write, register_write,
                result_src, alu_src_a, alu_src_b, alu_control,
                immediate_source, illegal};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (op=%b f3=%b) t=%0t", name, act, req, opcode, funct3, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (op=%b f3=%b) t=%0t", name, act, req, opcode, funct3, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] mk(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, a, b,
                                      input logic [2:0] alu, imm,
                                      input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
  endfunction

  // {legal, alu code} from the funct3 table; sub is only meaningful for R-type.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return {1'b1, sub ? 3'b001 : 3'b000};
      3'd2:    return {1'b1, 3'b100};
      3'd4:    return {1'b1, 3'b101};
      3'd6:    return {1'b1, 3'b011};
      3'd7:    return {1'b1, 3'b010};
      default: return 4'b0000;
    endcase
  endfunction

  // Expected output word for every cycle of one instruction, starting at FETCH.
  task automatic model(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, z, s, output bit trap);
    logic [3:0] al;
    logic [W-1:0] wb;
    bit taken;
    trap  = 0;
    taken = 0;
    wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000,
                       (op == OP_JAL) ? 3'b011 : 3'b010, 1'b0));
    case (op)
      OP_LOAD, OP_STORE: begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000,
                           op[5] ? 3'b001 : 3'b000, 1'b0));
        if (op == OP_STORE)
          exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0));
        else begin
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0));
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0));
        end
      end
      OP_R, OP_I: begin
        al = alu_of(f3, (op == OP_R) ? f7 : 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                           (op == OP_R) ? 2'b00 : 2'b01, al[2:0], 3'b000, 1'b0));
        if (al[3]) exp_q.push_back(wb);
        else       trap = 1;
      end
      OP_JAL: begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0));
        exp_q.push_back(wb);
      end
      OP_JALR: begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0));
      end
      OP_BR: begin
        case (f3)
          3'd0:    taken = z;
          3'd1:    taken = !z;
          3'd4:    taken = s;
          3'd5:    taken = !s;
          default: trap  = 1;
        endcase
        exp_q.push_back(mk(trap ? 1'b0 : taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                           3'b001, 3'b000, 1'b0));
      end
      OP_LUI:
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1'b0));
      default: trap = 1;
    endcase
    if (trap)
      repeat (TRAP_CYC)
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1));
  endtask

  // ---------------- driver tasks ----------------
  // Entered mid-cycle with the DUT in FETCH; leaves mid-cycle in FETCH (or TRAP).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, z, s, output int cycles, output bit trap);
    int n;
    int limit;
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z; sign = s;
    model(op, f3, f7, z, s, trap);
    limit = trap ? exp_q.size() : 8;
    #1;
    n = 0;
    do begin
      if (exp_q.size() > 0) check("step", got, exp_q.pop_front());
      else begin
        checks++; errors++;
        $display("FAIL overrun: no refetch after %0d cycles, got %h (op=%b f3=%b)", n, got, op, f3);
      end
      @(posedge clk); #2;
      n++;
    end while (!ir_write && n < limit);
    check_int("len", exp_q.size(), 0);
    if (!trap) check("refetch", {17'd0, ir_write}, 18'd1);
    cycles = n;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1 check("rst_quiet", got, '0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1 check("rst_fetch", got,
             mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       s;
    int         cyc;   // expected cycles per instruction, 0 = traps
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  logic [6:0] legal_ops[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit trap;
    logic [6:0] op;

    vecs[0]  = '{OP_LOAD,  3'b010, 1'b0, 1'b0, 1'b0, 5};
    vecs[1]  = '{OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 4};
    vecs[2]  = '{OP_R,     3'b000, 1'b0, 1'b0, 1'b0, 4};
    vecs[3]  = '{OP_R,     3'b000, 1'b1, 1'b0, 1'b0, 4};
    vecs[4]  = '{OP_R,     3'b010, 1'b0, 1'b0, 1'b0, 4};
    vecs[5]  = '{OP_R,     3'b110, 1'b0, 1'b0, 1'b0, 4};
    vecs[6]  = '{OP_I,     3'b000, 1'b1, 1'b0, 1'b0, 4};
    vecs[7]  = '{OP_I,     3'b100, 1'b0, 1'b0, 1'b0, 4};
    vecs[8]  = '{OP_I,     3'b111, 1'b0, 1'b0, 1'b0, 4};
    vecs[9]  = '{OP_R,     3'b001, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{OP_JAL,   3'b000, 1'b0, 1'b0, 1'b0, 4};
    vecs[11] = '{OP_JALR,  3'b000, 1'b0, 1'b0, 1'b0, 4};
    vecs[12] = '{OP_BR,    3'b000, 1'b0, 1'b1, 1'b0, 3};
    vecs[13] = '{OP_BR,    3'b001, 1'b0, 1'b1, 1'b0, 3};
    vecs[14] = '{OP_BR,    3'b001, 1'b0, 1'b0, 1'b0, 3};
    vecs[15] = '{OP_BR,    3'b100, 1'b0, 1'b0, 1'b1, 3};
    vecs[16] = '{OP_BR,    3'b101, 1'b0, 1'b0, 1'b1, 3};
    vecs[17] = '{OP_BR,    3'b010, 1'b0, 1'b0, 1'b0, 0};
    vecs[18] = '{OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, 3};
    vecs[19] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0};
    vecs[20] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 0};
    vecs[21] = '{OP_I,     3'b101, 1'b0, 1'b0, 1'b0, 0};

    legal_ops[0] = OP_LOAD; legal_ops[1] = OP_STORE; legal_ops[2] = OP_R;
    legal_ops[3] = OP_I;    legal_ops[4] = OP_JAL;   legal_ops[5] = OP_JALR;
    legal_ops[6] = OP_BR;   legal_ops[7] = OP_LUI;

    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; sign = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    // Reset arriving mid-instruction while in EXEC_R.
    opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b1;
    #1 check("pre_fetch", got, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0));
    @(posedge clk); #2;
    check("pre_decode", got, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 1'b0));
    @(posedge clk); #2;
    check("pre_exec_sub", got, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0));
    do_reset(3);

    // Table vectors.
    for (int i = 0; i < NV; i++) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].s, cyc, trap);
      if (vecs[i].cyc == 0) begin
        check("trap_illegal", {17'd0, illegal}, 18'd1);
        do_reset(1);
      end else begin
        check_int("cpi", cyc, vecs[i].cyc);
      end
    end

    // Random instructions against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
      else                          op = 7'($urandom_range(0, 127));
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc, trap);
      if (trap) do_reset(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
